// File: rtl/iob_ext_mem_bank_2p.sv
// rtl/iob_ext_mem_bank_2p.sv - N-block simple-dual-port RAM bank responder with zero-fill on reset
// Read latency 1 or 2, selectable collision policy, hold-last-value read data.
module iob_ext_mem_bank_2p #(
  parameter int N            = 2,
  parameter int MINDATA_W    = 32,
  parameter int MINADDR_W    = 8,
  parameter int R_LAT        = 1,
  parameter int WRITE_FIRST  = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [N-1:0]           ext_mem_w_en,
  input  logic [N*MINDATA_W-1:0] ext_mem_w_data,
  input  logic [N*MINADDR_W-1:0] ext_mem_w_addr,
  input  logic                   ext_mem_r_en,
  input  logic [N*MINADDR_W-1:0] ext_mem_r_addr,
  output logic [N*MINDATA_W-1:0] ext_mem_r_data,
  output logic                   init_busy,
  output logic                   init_done
);

  localparam int DEPTH = 2 ** MINADDR_W;
  localparam logic [MINADDR_W-1:0] LAST_ADDR = MINADDR_W'(DEPTH - 1);

  if (!(R_LAT == 1 || R_LAT == 2)) begin : g_bad_r_lat
    $error("iob_ext_mem_bank_2p: R_LAT must be 1 or 2");
  end

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                 state_q;
  logic [MINADDR_W-1:0]   cnt_q;
  logic                   init_busy_q;
  logic                   init_done_q;

  logic [MINDATA_W-1:0]   mem_q [N][DEPTH];

  logic [N-1:0]           wr_en;
  logic [N*MINADDR_W-1:0] wr_addr;
  logic [N*MINDATA_W-1:0] wr_data;

  logic [N*MINDATA_W-1:0] rd1_q, rd1_d;
  logic                   vld1_q, vld1_d;
  logic [N*MINDATA_W-1:0] rd2_q, rd2_d;

  // Zero-fill sequencer: one word per block per cycle, READY is sticky until reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt_q       <= '0;
      init_busy_q <= (CLEAR_ON_RST != 0);
      init_done_q <= (CLEAR_ON_RST == 0);
      if (CLEAR_ON_RST != 0) state_q <= ST_CLEAR;
      else                   state_q <= ST_READY;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q     <= ST_READY;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  // Write port mux: the fill owns every block while clearing, external writes are dropped.
  always_comb begin
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    if (!ap_rst) begin
      if (state_q == ST_CLEAR) begin
        wr_en = '1;
        for (int p = 0; p < N; p++) wr_addr[p*MINADDR_W +: MINADDR_W] = cnt_q;
      end else begin
        wr_en   = ext_mem_w_en;
        wr_addr = ext_mem_w_addr;
        wr_data = ext_mem_w_data;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    for (int p = 0; p < N; p++) begin
      if (wr_en[p]) mem_q[p][wr_addr[p*MINADDR_W +: MINADDR_W]] <= wr_data[p*MINDATA_W +: MINDATA_W];
    end
  end

  // Array read samples pre-write contents; WRITE_FIRST swaps in the incoming word on a hit.
  always_comb begin
    rd1_d = rd1_q;
    if (ext_mem_r_en) begin
      for (int p = 0; p < N; p++) begin
        if (state_q == ST_CLEAR) begin
          rd1_d[p*MINDATA_W +: MINDATA_W] = '0;
        end else if ((WRITE_FIRST != 0) && ext_mem_w_en[p] &&
                     (ext_mem_w_addr[p*MINADDR_W +: MINADDR_W] == ext_mem_r_addr[p*MINADDR_W +: MINADDR_W])) begin
          rd1_d[p*MINDATA_W +: MINDATA_W] = ext_mem_w_data[p*MINDATA_W +: MINDATA_W];
        end else begin
          rd1_d[p*MINDATA_W +: MINDATA_W] = mem_q[p][ext_mem_r_addr[p*MINADDR_W +: MINADDR_W]];
        end
      end
    end
    vld1_d = ext_mem_r_en;
    rd2_d  = vld1_q ? rd1_q : rd2_q;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rd1_q  <= '0;
      vld1_q <= 1'b0;
      rd2_q  <= '0;
    end else begin
      rd1_q  <= rd1_d;
      vld1_q <= vld1_d;
      rd2_q  <= rd2_d;
    end
  end

  assign ext_mem_r_data = (R_LAT == 2) ? rd2_q : rd1_q;
  assign init_busy      = init_busy_q;
  assign init_done      = init_done_q;

endmodule
